// File: rtl/instruction_fetch_unit.sv
// Fetch stage for the single-cycle MIPS core: PC ownership, imem req/ack fetch, next-PC selection.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        hold,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] next_pc;
  logic [31:0] branch_off;

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_ISSUE);

  // Jump beats a taken branch; the branch offset is a sign-extended word offset.
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  // Retire on each issue that is released; stall on each fetch cycle without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      if (state_q == S_ISSUE && !hold) begin
        retired_q <= retired_q + 32'd1;
      end
      if (state_q == S_FETCH && !imem_ack) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`else
  assign retired_cnt = 32'd0;
  assign stall_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit against a PC/counter reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_A = 32'h0040_0000;
  localparam logic [31:0] RST_J = 32'h8000_0010;
`ifdef IFU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        rstJ;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        hold;
  logic        branch;
  logic        zero;
  logic        jump;

  logic        imem_req,    imemReqJ;
  logic [31:0] imem_addr,   imemAddrJ;
  logic [31:0] instr,       instrJ;
  logic [5:0]  opcode,      opcodeJ;
  logic        instr_valid, instrValidJ;
  logic [31:0] pc,          pcJ;
  logic [31:0] pc_plus4,    pcPlus4J;
  logic [31:0] retired_cnt, retiredCntJ;
  logic [31:0] stall_cnt,   stallCntJ;

  int          tests;
  int          fails;
  logic [31:0] expPc;
  logic [31:0] expRetired;
  logic [31:0] expStall;

  instruction_fetch_unit #(.RESET_PC(RST_A)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .hold(hold), .branch(branch), .zero(zero), .jump(jump),
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  instruction_fetch_unit #(.RESET_PC(RST_J)) dutJ (
    .clk(clk), .reset(rstJ),
    .imem_req(imemReqJ), .imem_addr(imemAddrJ), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instrJ), .opcode(opcodeJ), .instr_valid(instrValidJ),
    .pc(pcJ), .pc_plus4(pcPlus4J),
    .hold(hold), .branch(branch), .zero(zero), .jump(jump),
    .retired_cnt(retiredCntJ), .stall_cnt(stallCntJ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // MIPS next-PC rule expressed with plain signed arithmetic
  function automatic logic [31:0] modelNext(input logic [31:0] curPc, input logic [31:0] ins,
                                            input logic br, input logic z, input logic jp);
    logic [31:0] p4;
    int          off;
    p4 = curPc + 32'd4;
    if (jp) return {p4[31:28], ins[25:0], 2'b00};
    if (br && z) begin
      off = int'($signed(ins[15:0]));
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  // Runs one instruction from the S_FETCH negedge through to the next S_FETCH negedge
  task automatic doInstr(input logic [31:0] ins, input int ackDelay, input int holdCycles,
                         input logic br, input logic z, input logic jp, input string name);
    logic [31:0] nxt;
    for (int k = 0; k <= ackDelay; k++) begin
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== expPc || instr_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL %s fetch cyc%0d: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0",
                 name, k, imem_req, imem_addr, instr_valid, expPc);
      end
      imem_ack   = (k == ackDelay);
      imem_rdata = (k == ackDelay) ? ins : $urandom;
      hold       = 1'($urandom);
      branch     = 1'($urandom);
      zero       = 1'($urandom);
      jump       = 1'($urandom);
      @(negedge clk);
      if (k < ackDelay) expStall++;
    end
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    for (int h = 0; h <= holdCycles; h++) begin
      tests++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== ins || opcode !== ins[31:26] ||
          pc !== expPc || pc_plus4 !== expPc + 32'd4) begin
        fails++;
        $display("[TB] FAIL %s issue cyc%0d: valid=%b req=%b instr=%h op=%h pc=%h pc4=%h, expected 1 0 %h %h %h %h",
                 name, h, instr_valid, imem_req, instr, opcode, pc, pc_plus4,
                 ins, ins[31:26], expPc, expPc + 32'd4);
      end
      if (h < holdCycles) begin
        hold   = 1'b1;
        branch = 1'($urandom);
        zero   = 1'($urandom);
        jump   = 1'($urandom);
      end else begin
        hold   = 1'b0;
        branch = br;
        zero   = z;
        jump   = jp;
      end
      @(negedge clk);
    end
    nxt = modelNext(expPc, ins, br, z, jp);
    expPc = nxt;
    expRetired++;
    hold = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    tests++;
    if (retired_cnt !== (PERF ? expRetired : 32'd0) || stall_cnt !== (PERF ? expStall : 32'd0)) begin
      fails++;
      $display("[TB] FAIL %s counters: retired=%0d stall=%0d, expected %0d %0d", name,
               retired_cnt, stall_cnt, PERF ? expRetired : 32'd0, PERF ? expStall : 32'd0);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (pc !== RST_A || imem_addr !== RST_A || pc_plus4 !== RST_A + 32'd4 || instr !== 32'd0 ||
        opcode !== 6'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0 ||
        retired_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_state: pc=%h addr=%h pc4=%h instr=%h op=%h valid=%b req=%b ret=%0d stall=%0d",
               pc, imem_addr, pc_plus4, instr, opcode, instr_valid, imem_req, retired_cnt, stall_cnt);
    end
    tests++;
    if (pcJ !== RST_J || imemReqJ !== 1'b0 || instrValidJ !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_state_j: pc=%h req=%b valid=%b, expected %h 0 0",
               pcJ, imemReqJ, instrValidJ, RST_J);
    end
  endtask

  task automatic test_jump_priority();
    rstJ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (imemReqJ !== 1'b1 || imemAddrJ !== RST_J) begin
      fails++;
      $display("[TB] FAIL jump_fetch: req=%b addr=%h, expected 1 %h", imemReqJ, imemAddrJ, RST_J);
    end
    imem_ack   = 1'b1;
    imem_rdata = {6'd2, 26'h000_0040};
    @(negedge clk);
    imem_ack = 1'b0;
    tests++;
    if (instrValidJ !== 1'b1 || opcodeJ !== 6'd2) begin
      fails++;
      $display("[TB] FAIL jump_issue: valid=%b op=%h, expected 1 02", instrValidJ, opcodeJ);
    end
    branch = 1'b1; zero = 1'b1; jump = 1'b1; hold = 1'b0;
    @(negedge clk);
    tests++;
    if (imemReqJ !== 1'b1 || imemAddrJ !== 32'h8000_0100) begin
      fails++;
      $display("[TB] FAIL jump_target: req=%b addr=%h, expected 1 80000100", imemReqJ, imemAddrJ);
    end
    branch = 1'b0; zero = 1'b0; jump = 1'b0;
    rstJ = 1'b1;
  endtask

  task automatic test_reset_release();
    expPc = RST_A; expRetired = 32'd0; expStall = 32'd0;
    reset = 1'b0;
    @(negedge clk);
    doInstr({6'd0, 26'($urandom)}, 0, 0, 1'b0, 1'b0, 1'b0, "release");
    tests++;
    if (imem_addr !== 32'h0040_0004) begin
      fails++;
      $display("[TB] FAIL release_next: addr=%h, expected 00400004", imem_addr);
    end
  endtask

  task automatic test_branch();
    doInstr({6'd2, 26'h000_0040}, 0, 0, 1'b0, 1'b0, 1'b1, "to_100");
    doInstr({6'd4, 10'($urandom), 16'hFFFE}, 1, 0, 1'b1, 1'b1, 1'b0, "beq_taken");
    tests++;
    if (imem_addr !== 32'h0000_00FC) begin
      fails++;
      $display("[TB] FAIL beq_taken_addr: addr=%h, expected 000000fc", imem_addr);
    end
    doInstr({6'd2, 26'h000_0040}, 0, 1, 1'b0, 1'b0, 1'b1, "back_to_100");
    doInstr({6'd4, 10'($urandom), 16'hFFFE}, 0, 0, 1'b1, 1'b0, 1'b0, "beq_not_taken");
    tests++;
    if (imem_addr !== 32'h0000_0104) begin
      fails++;
      $display("[TB] FAIL beq_not_taken_addr: addr=%h, expected 00000104", imem_addr);
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] r0, s0;
    r0 = retired_cnt;
    s0 = stall_cnt;
    doInstr($urandom, 3, 2, 1'b0, 1'b0, 1'b0, "stall_hold");
    tests++;
    if (retired_cnt - r0 !== (PERF ? 32'd1 : 32'd0) || stall_cnt - s0 !== (PERF ? 32'd3 : 32'd0)) begin
      fails++;
      $display("[TB] FAIL stall_hold_delta: retired+%0d stall+%0d", retired_cnt - r0, stall_cnt - s0);
    end
  endtask

  task automatic test_wrap();
    doInstr({6'd2, 26'h000_0000}, 0, 0, 1'b0, 1'b0, 1'b1, "to_zero");
    doInstr({6'd4, 10'($urandom), 16'hFFFE}, 0, 0, 1'b1, 1'b1, 1'b0, "to_top");
    tests++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      fails++;
      $display("[TB] FAIL wrap_top: addr=%h, expected fffffffc", imem_addr);
    end
    doInstr({6'd0, 26'($urandom)}, 0, 0, 1'b0, 1'b0, 1'b0, "wrap");
    tests++;
    if (imem_addr !== 32'h0000_0000) begin
      fails++;
      $display("[TB] FAIL wrap_zero: addr=%h, expected 00000000", imem_addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      doInstr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              1'($urandom), 1'($urandom), 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid_fetch();
    imem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if (imem_req !== 1'b0 || pc !== RST_A || instr !== 32'd0 || instr_valid !== 1'b0 ||
        retired_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      fails++;
      $display("[TB] FAIL async_reset: req=%b pc=%h instr=%h valid=%b ret=%0d stall=%0d",
               imem_req, pc, instr, instr_valid, retired_cnt, stall_cnt);
    end
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (instr !== 32'd0 || imem_req !== 1'b1 || imem_addr !== RST_A || instr_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stray_ack: instr=%h req=%b addr=%h valid=%b, expected 0 1 %h 0",
               instr, imem_req, imem_addr, instr_valid, RST_A);
    end
    imem_ack = 1'b0;
    expPc = RST_A; expRetired = 32'd0; expStall = 32'd0;
    doInstr($urandom, 1, 0, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b0; rstJ = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    hold = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    expPc = RST_A; expRetired = 32'd0; expStall = 32'd0;
    #2;
    reset = 1'b1;
    rstJ  = 1'b1;
    test_reset();
    test_jump_priority();
    test_reset_release();
    test_branch();
    test_stall_hold();
    test_wrap();
    test_random();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
